// File: rtl/saa_pkg.sv
// saa_pkg: shared state encoding, latency formula and result-reduction helpers for the systolic engine
package saa_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;
  function automatic int latency(input int n);
    return 3 * n * n + 3 * n - 1;
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic signed [63:0] truncate(input logic signed [63:0] v, input int w);
    return v & ((64'sd1 <<< w) - 64'sd1);
  endfunction
endpackage

// File: rtl/mac_pe.sv
// mac_pe: one systolic cell, forwards a right and b down, accumulates signed a*b
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = a_in * b_in;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: NxN output-stationary C = A x B over a shared word memory.
// Define SATURATE_EN to clamp results on write-back instead of truncating them.
module systolic_mm_engine
  import saa_pkg::*;
#(
  parameter int N      = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W-1:0] base_address_A,
  input  logic [ADDR_W-1:0] base_address_B,
  input  logic [ADDR_W-1:0] base_address_C,
  output logic              complete,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);
  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] base_a, base_b, base_c, k_addr;
  logic signed [DATA_W-1:0] a_buf [NN];
  logic signed [DATA_W-1:0] b_buf [NN];
  logic signed [DATA_W-1:0] a_edge [N];
  logic signed [DATA_W-1:0] b_edge [N];
  logic signed [DATA_W-1:0] a_fwd [N][N];
  logic signed [DATA_W-1:0] b_fwd [N][N];
  logic signed [ACC_W-1:0] acc [NN];
  logic signed [63:0] wide, red;
  logic accept, load_last, comp_last, write_last, run;
  assign accept     = init && (state == IDLE || state == DONE);
  assign load_last  = state == LOAD && cnt == CW'(2 * NN);
  assign comp_last  = state == COMPUTE && cnt == CW'(3 * N - 3);
  assign write_last = state == WRITE && cnt == CW'(NN - 1);
  assign run        = state == COMPUTE;
  assign k_addr     = ADDR_W'(cnt);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = init ? LOAD : state;
      LOAD:       nxt = load_last ? COMPUTE : LOAD;
      COMPUTE:    nxt = comp_last ? WRITE : COMPUTE;
      WRITE:      nxt = write_last ? DONE : WRITE;
      default:    nxt = IDLE;
    endcase
  end
  // each LOAD cycle captures the word requested on the previous one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      for (int k = 0; k < NN; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        base_a <= base_address_A;
        base_b <= base_address_B;
        base_c <= base_address_C;
      end
      if (state == LOAD && cnt != '0) begin
        if (int'(cnt) <= NN) a_buf[int'(cnt) - 1] <= mem_rdata;
        else b_buf[int'(cnt) - 1 - NN] <= mem_rdata;
      end
    end
  end
  // skewed edge injection: row i lags by i cycles, column j by j cycles
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (run && int'(cnt) >= i && int'(cnt) - i < N) begin
        a_edge[i] = a_buf[i * N + int'(cnt) - i];
        b_edge[i] = b_buf[(int'(cnt) - i) * N + i];
      end
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_W-1:0] a_in, b_in;
      if (j == 0) begin : g_al
        assign a_in = a_edge[i];
      end else begin : g_ai
        assign a_in = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in = b_edge[j];
      end else begin : g_bi
        assign b_in = b_fwd[i-1][j];
      end
      mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .rst(rst), .clr(load_last), .en(run),
        .a_in(a_in), .b_in(b_in),
        .a_out(a_fwd[i][j]), .b_out(b_fwd[i][j]),
        .acc(acc[i * N + j])
      );
    end
  end
  always_comb begin
    wide = 64'(acc[state == WRITE ? int'(cnt) : 0]);
`ifdef SATURATE_EN
    red = saturate(wide, DATA_W);
`else
    red = truncate(wide, DATA_W);
`endif
    complete  = state == DONE;
    mem_rd_en = state == LOAD && int'(cnt) < 2 * NN;
    mem_wr_en = state == WRITE;
    mem_addr  = mem_rd_en ? (int'(cnt) < NN ? base_a + k_addr : base_b + k_addr - ADDR_W'(NN))
              : mem_wr_en ? base_c + k_addr : '0;
    mem_wdata = mem_wr_en ? red[DATA_W-1:0] : '0;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised NxN output-stationary systolic matrix-multiply engine: C = A x B.
- A, B and C sit in one shared single-port word memory, each at its own base address, stored row-major.
- Sequence per job: load A and B into local buffers, stream skewed operands through an NxN MAC grid, write C back.
- Generalises the fixed 5x5, 8-bit accelerator to arbitrary N, data width and address width, with defined latency, optional saturation and explicit reset-abort behaviour.

Parameters:
- N, 5: matrix dimension (N >= 2).
- DATA_W, 8: element and memory word width; signed two's complement.
- ADDR_W, 8: memory address width; all address arithmetic is modulo 2^ADDR_W.
- ACC_W, 2*DATA_W+$clog2(N): PE accumulator width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  job start; sampled only in IDLE or DONE.
- base_address_A  in  ADDR_W  base of A; sampled with init.
- base_address_B  in  ADDR_W  base of B; sampled with init.
- base_address_C  in  ADDR_W  base of C; sampled with init.
- complete  out  1  high in DONE until the next accepted init or rst.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe; data returns one cycle later.
- mem_rdata  in  DATA_W  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.

Behaviour:
- Reset values: state IDLE; complete, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0; buffers and accumulators cleared.
- States: IDLE -> LOAD -> COMPUTE -> WRITE -> DONE. DONE -> LOAD on init.
- init in LOAD, COMPUTE or WRITE is ignored. Base addresses are latched at the accepting edge.
- LOAD, 2N^2+1 cycles:
  - Cycle k < N^2: read address base_A+k. Cycle N^2 <= k < 2N^2: read address base_B+(k-N^2).
  - mem_rd_en is high for k < 2N^2.
  - Each cycle captures the word requested on the previous cycle into the A or B buffer; the final cycle captures only.
- COMPUTE, 3N-2 cycles (t = 0..3N-3):
  - Row edge i receives A[i][t-i]; column edge j receives B[t-j][j]. Out-of-range indices inject 0.
  - PE(i,j) registers a rightward and b downward and adds a*b, signed, sign-extended to ACC_W.
  - PE(i,j) therefore sees term k at cycle k+i+j.
  - Accumulators clear on entry to COMPUTE.
- WRITE, N^2 cycles:
  - Cycle m: mem_wr_en=1, mem_addr=base_C+m, mem_wdata = result of C[m/N][m%N] reduced to DATA_W.
  - Reduction without the optional feature: keep the low DATA_W bits.
  - No read and write ever occur in the same cycle.
- DONE: complete=1, all strobes 0.
- Latency: complete rises exactly 3N^2+3N-1 cycles after the accepting edge (89 for N=5).
- Address overflow wraps modulo 2^ADDR_W. Overlapping regions are legal; A and B are fully buffered before any write.
- rst during any state takes effect at that edge: return to IDLE, clear complete, drive strobes low the next cycle, issue no further writes. Partial C writes already made remain in memory.

Optional Feature:
- SATURATE_EN defined: WRITE clamps the accumulator to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- SATURATE_EN undefined: WRITE truncates to the low DATA_W bits.
- Latency is identical in both builds.

Decomposition:
- Package saa_pkg holds:
  - state enum (IDLE, LOAD, COMPUTE, WRITE, DONE);
  - a latency constant function of N;
  - saturate/truncate helper functions.
- Sub-module mac_pe: one PE (operand forwarding registers plus accumulator, with clear and enable), instantiated N^2 times in a generate grid.

Test Plan:
- Identity: N=5, A=I at 0, B=k (0..24) at 25, C base 50 -> mem[50+k]=k; complete 89 cycles after init edge; exactly 25 write strobes.
- All-ones: A=B=all 1s -> every C word = 5; a second init from DONE recomputes the same result with the same latency.
- Overflow: A=B=all 100 -> accumulator 50000 per element. SATURATE_EN writes 127; without it writes 50000 mod 256 = 80 (0x50).
- Negatives: A=all -3, B=all 2 -> all C = -30 (0xE2).
- Abort: assert rst at COMPUTE cycle 4 -> next cycle state IDLE, complete=0, no mem_wr_en afterward. A fresh init then completes correctly.
- Busy/wrap: init pulsed during LOAD is ignored. base_C=250 with ADDR_W=8 -> writes go to 250..255, then 0..18.
